frogger_round_controller: RTL and testbench
===========================================

Name: frogger_round_controller

Overview:
- Game-round sequencer sitting between the car-collision detector and the frog/car movers.
- Consumes the detector's collision flag and the frog row, and owns lives, score, death/respawn timing and game-over.
- Issues respawn and freeze commands back to the movers.
- One instance per game, in the top-level game core.

Parameters:
c_LIVES, 3, lives loaded at game start (1..3)
c_DEATH_FRAMES, 60, frame ticks the board stays frozen after a hit (1..255)
c_GOAL_Y, 0, frog row counted as reaching home
c_WIN_SCORE, 5, homes needed to win (1..255)
c_INVULN_FRAMES, 30, frame ticks of post-respawn immunity (only with optional feature)

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  synchronous, active-high reset
i_Start  in  1  single-cycle start/restart request (button edge)
i_Frame_Tick  in  1  single-cycle pulse, once per video frame
i_Collided  in  1  level; frog overlaps a car (from collision detector)
i_Frogger_Y  in  6  current frog row
o_State  out  3  FSM state: IDLE=0 RESPAWN=1 PLAYING=2 DYING=3 GAME_OVER=4 WIN=5
o_Lives  out  2  remaining lives
o_Score  out  8  homes reached this game
o_Respawn  out  1  single-cycle pulse; movers reload the frog to its origin
o_Freeze  out  1  level; movers hold all positions
o_Game_Over  out  1  level; high in GAME_OVER or WIN

Behaviour:
- One clock i_Clk. Reset is synchronous and active-high on i_Reset.
- All outputs are registered. Reset values:
  - State IDLE, o_Lives=0, o_Score=0, o_Respawn=0, o_Freeze=1, o_Game_Over=0, frame counter 0.
- Reset mid-game is immediate on the next edge; no pending pulse survives.
- IDLE: o_Freeze=1. On i_Start: load o_Lives=c_LIVES, clear o_Score, go to RESPAWN.
- RESPAWN: lasts exactly 1 cycle.
  - o_Respawn=1 that cycle, o_Freeze=1.
  - Next state PLAYING. Guard flag set.
- PLAYING: o_Freeze=0.
  - Guard flag: i_Collided is ignored in the first PLAYING cycle, to absorb detector latency after the frog reload. The flag clears after that cycle.
  - i_Collided=1 (guard clear):
    - o_Lives decrements, saturating at 0.
    - Frame counter clears; go to DYING.
  - Else if i_Frogger_Y==c_GOAL_Y:
    - o_Score increments, saturating at 255.
    - If the new score == c_WIN_SCORE, go to WIN; else go to RESPAWN.
  - Collision and goal in the same cycle: collision wins and the score is unchanged.
  - i_Start is ignored in PLAYING.
- DYING: o_Freeze=1.
  - Counter increments on each i_Frame_Tick.
  - When the counter reaches c_DEATH_FRAMES, in that same cycle go to GAME_OVER if o_Lives==0, else RESPAWN.
  - i_Collided is ignored; no double decrement.
- GAME_OVER / WIN: o_Freeze=1, o_Game_Over=1.
  - o_Lives and o_Score are held for display.
  - i_Start behaves as in IDLE: reload lives, clear score, go to RESPAWN.
- Timing and width rules:
  - Latency from i_Collided to o_Freeze=1 is 1 cycle.
  - A tick arriving in the same cycle as the state entry is not counted.
  - Counter is 8 bits and never wraps: it is cleared on every entry to DYING.
  - Illegal o_State encodings (6, 7) return to IDLE on the next cycle.

Optional Feature:
- Macro: FROGGER_INVULN_EN.
- Defined:
  - RESPAWN also loads a separate invulnerability counter with c_INVULN_FRAMES.
  - In PLAYING the counter decrements on each i_Frame_Tick.
  - While it is non-zero, i_Collided is ignored; the goal check still applies.
  - Counter clears on reset and on leaving PLAYING.
- Undefined:
  - No counter logic is generated; only the 1-cycle guard applies.
  - c_INVULN_FRAMES is unused.

Test Plan:
- Reset, then i_Start pulse -> next cycle RESPAWN with o_Respawn=1 and o_Lives=3; following cycle PLAYING, o_Freeze=0, o_Score=0.
- PLAYING, i_Collided=1 for one cycle -> o_Lives 3->2, DYING, o_Freeze=1; after exactly 60 ticks RESPAWN pulses once, then PLAYING.
- Three collisions each followed by 60 ticks -> o_Lives=0, o_State=4, o_Game_Over=1; i_Start -> o_Lives=3, o_Score=0, RESPAWN.
- i_Frogger_Y=0 five separate times (each via RESPAWN) -> o_Score 1..5, final state WIN; same-cycle i_Collided=1 with Y=0 -> DYING and score unchanged.
- i_Collided held high across RESPAWN -> ignored in the first PLAYING cycle, death on the second; no second decrement during DYING; i_Reset mid-DYING -> IDLE, o_Lives=0.
- FROGGER_INVULN_EN defined: i_Collided=1 for 29 ticks after respawn -> no death; on tick 30 -> DYING.

Source files
------------

// File: rtl/frogger_round_controller.sv
// frogger_round_controller: round sequencer owning lives, score, death/respawn timing and game-over.
// Ports: i_Clk, i_Reset (sync, active-high), i_Start (start pulse), i_Frame_Tick (per-frame pulse),
//   i_Collided (frog/car overlap), i_Frogger_Y (frog row) -> o_State, o_Lives, o_Score,
//   o_Respawn (reload pulse), o_Freeze (movers hold), o_Game_Over (GAME_OVER or WIN).
// Optional FROGGER_INVULN_EN: post-respawn invulnerability lasting c_INVULN_FRAMES frame ticks.
module frogger_round_controller #(
  parameter int c_LIVES = 3,
  parameter int c_DEATH_FRAMES = 60,
  parameter int c_GOAL_Y = 0,
  parameter int c_WIN_SCORE = 5
`ifdef FROGGER_INVULN_EN
  , parameter int c_INVULN_FRAMES = 30
`endif
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Start,
  input  logic       i_Frame_Tick,
  input  logic       i_Collided,
  input  logic [5:0] i_Frogger_Y,
  output logic [2:0] o_State,
  output logic [1:0] o_Lives,
  output logic [7:0] o_Score,
  output logic       o_Respawn,
  output logic       o_Freeze,
  output logic       o_Game_Over
);
  typedef enum logic [2:0] {IDLE, RESPAWN, PLAYING, DYING, GAME_OVER, WIN} state_t;
  state_t state;
  logic [7:0] frame_cnt;
  logic [7:0] cnt_nxt;
  logic [7:0] score_nxt;
  logic guard;
  logic immune;
  assign o_State = state;
  assign cnt_nxt = frame_cnt + 8'd1;
  assign score_nxt = (o_Score == 8'hff) ? 8'hff : o_Score + 8'd1;
`ifdef FROGGER_INVULN_EN
  logic [7:0] inv_cnt;
  assign immune = guard || inv_cnt != 8'd0;
  // Stale value outside PLAYING is never consulted; it is zeroed there anyway.
  always_ff @(posedge i_Clk)
    if (i_Reset || (state != PLAYING && state != RESPAWN)) inv_cnt <= 8'd0;
    else if (state == RESPAWN) inv_cnt <= 8'(c_INVULN_FRAMES);
    else if (i_Frame_Tick && inv_cnt != 8'd0) inv_cnt <= inv_cnt - 8'd1;
`else
  assign immune = guard;
`endif
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state       <= IDLE;
      o_Lives     <= 2'd0;
      o_Score     <= 8'd0;
      o_Respawn   <= 1'b0;
      o_Freeze    <= 1'b1;
      o_Game_Over <= 1'b0;
      frame_cnt   <= 8'd0;
      guard       <= 1'b0;
    end else begin
      o_Respawn <= 1'b0;
      case (state)
        IDLE, GAME_OVER, WIN: if (i_Start) begin
          state       <= RESPAWN;
          o_Lives     <= 2'(c_LIVES);
          o_Score     <= 8'd0;
          o_Respawn   <= 1'b1;
          o_Freeze    <= 1'b1;
          o_Game_Over <= 1'b0;
        end
        RESPAWN: begin
          state    <= PLAYING;
          o_Freeze <= 1'b0;
          guard    <= 1'b1;
        end
        PLAYING: begin
          guard <= 1'b0;
          // Collision has priority over reaching home in the same cycle.
          if (i_Collided && !immune) begin
            state     <= DYING;
            o_Freeze  <= 1'b1;
            o_Lives   <= (o_Lives == 2'd0) ? 2'd0 : o_Lives - 2'd1;
            frame_cnt <= 8'd0;
          end else if (i_Frogger_Y == 6'(c_GOAL_Y)) begin
            o_Score  <= score_nxt;
            o_Freeze <= 1'b1;
            if (score_nxt == 8'(c_WIN_SCORE)) begin
              state       <= WIN;
              o_Game_Over <= 1'b1;
            end else begin
              state     <= RESPAWN;
              o_Respawn <= 1'b1;
            end
          end
        end
        DYING: if (i_Frame_Tick) begin
          frame_cnt <= cnt_nxt;
          if (cnt_nxt == 8'(c_DEATH_FRAMES)) begin
            if (o_Lives == 2'd0) begin
              state       <= GAME_OVER;
              o_Game_Over <= 1'b1;
            end else begin
              state     <= RESPAWN;
              o_Respawn <= 1'b1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          o_Freeze    <= 1'b1;
          o_Game_Over <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_frogger_round_controller.sv
// tb_frogger_round_controller: randomized scoreboard bench against a rule-level round model.
module tb_frogger_round_controller;
  localparam int LIVES = 3;
  localparam int DEATH = 60;
  localparam int GOAL = 0;
  localparam int WINS = 5;
`ifdef FROGGER_INVULN_EN
  localparam int INV_LOAD = 30;
`else
  localparam int INV_LOAD = 0;
`endif
  localparam int S_IDLE = 0, S_RESPAWN = 1, S_PLAYING = 2, S_DYING = 3, S_OVER = 4, S_WIN = 5;
  logic i_Clk = 1'b0;
  logic i_Reset = 1'b1, i_Start = 1'b0, i_Frame_Tick = 1'b0, i_Collided = 1'b0;
  logic [5:0] i_Frogger_Y = 6'd10;
  logic [2:0] o_State;
  logic [1:0] o_Lives;
  logic [7:0] o_Score;
  logic o_Respawn, o_Freeze, o_Game_Over;
  typedef struct {int st; int lives; int score; int rsp; int frz; int go;} exp_t;
  exp_t q[$];
  int n_checks = 0, n_pass = 0;
  int m_st = S_IDLE, m_lives = 0, m_score = 0, m_ticks = 0, m_inv = 0;
  bit m_fresh = 0;
  always #5 i_Clk = ~i_Clk;
  frogger_round_controller dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_Frame_Tick(i_Frame_Tick),
    .i_Collided(i_Collided), .i_Frogger_Y(i_Frogger_Y), .o_State(o_State), .o_Lives(o_Lives),
    .o_Score(o_Score), .o_Respawn(o_Respawn), .o_Freeze(o_Freeze), .o_Game_Over(o_Game_Over)
  );
  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask
  task automatic new_game();
    m_lives = LIVES;
    m_score = 0;
    m_st = S_RESPAWN;
  endtask
  task automatic model(bit r, bit s, bit t, bit c, int y);
    bit shielded;
    if (r) begin
      m_st = S_IDLE; m_lives = 0; m_score = 0; m_ticks = 0; m_inv = 0; m_fresh = 0;
    end else if (m_st == S_IDLE || m_st == S_OVER || m_st == S_WIN) begin
      if (s) new_game();
    end else if (m_st == S_RESPAWN) begin
      m_st = S_PLAYING; m_fresh = 1; m_inv = INV_LOAD;
    end else if (m_st == S_PLAYING) begin
      shielded = m_fresh || m_inv > 0;
      m_fresh = 0;
      if (t && m_inv > 0) m_inv--;
      if (c && !shielded) begin
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        m_ticks = 0; m_st = S_DYING; m_inv = 0;
      end else if (y == GOAL) begin
        m_score = (m_score < 255) ? m_score + 1 : 255;
        m_st = (m_score == WINS) ? S_WIN : S_RESPAWN;
        m_inv = 0;
      end
    end else if (m_st == S_DYING) begin
      if (t) m_ticks++;
      if (m_ticks == DEATH) m_st = (m_lives == 0) ? S_OVER : S_RESPAWN;
    end
  endtask
  task automatic cyc(bit r, bit s, bit t, bit c, int y);
    exp_t e;
    @(negedge i_Clk);
    i_Reset = r; i_Start = s; i_Frame_Tick = t; i_Collided = c; i_Frogger_Y = 6'(y);
    model(r, s, t, c, y);
    e.st = m_st; e.lives = m_lives; e.score = m_score;
    e.rsp = int'(m_st == S_RESPAWN);
    e.frz = int'(m_st != S_PLAYING);
    e.go = int'(m_st == S_OVER || m_st == S_WIN);
    q.push_back(e);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge i_Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state", int'(o_State), e.st);
        chk("lives", int'(o_Lives), e.lives);
        chk("score", int'(o_Score), e.score);
        chk("respawn", int'(o_Respawn), e.rsp);
        chk("freeze", int'(o_Freeze), e.frz);
        chk("game_over", int'(o_Game_Over), e.go);
      end
    end
  end
  initial begin : stimulus
    repeat (2) cyc(1, 0, 0, 0, 10);
    cyc(0, 1, 0, 0, 10);
    cyc(0, 0, 1, 0, 10);
    cyc(0, 0, 0, 0, 10);
    cyc(0, 0, 0, 1, 10);
    for (int i = 0; i < 130; i++) cyc(0, 0, i[0], 0, 10);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 10);
      cyc(0, 0, 1, 1, 10);
      for (int i = 0; i < 70; i++) cyc(0, 0, 1, 0, 10);
    end
    cyc(0, 1, 0, 0, 10);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0, 10);
      cyc(0, 0, 0, 0, 20);
      cyc(0, 0, 0, 0, GOAL);
    end
    cyc(0, 1, 0, 0, 10);
    cyc(0, 0, 0, 0, 10);
    cyc(0, 0, 0, 1, GOAL);
    cyc(0, 0, 0, 1, GOAL);
    for (int i = 0; i < 80; i++) cyc(0, 0, 1, 1, 10);
    for (int i = 0; i < 80; i++) cyc(0, 0, i[0], 1, 10);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 10);
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 1, 10);
    cyc(1, 0, 1, 1, 10);
    cyc(0, 0, 1, 0, 10);
    for (int i = 0; i < 15000; i++)
      cyc($urandom_range(0, 2999) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 24) == 0,
          ($urandom_range(0, 11) == 0) ? GOAL : int'($urandom_range(1, 63)));
    repeat (3) @(negedge i_Clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
